// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped prescaled timer/counter with compare match and irq
module mmio_timer #(
  parameter logic [8:0] BASE_ADDR = 9'h180,
  parameter int         PRE_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        read_hit,
  output logic        irq
);

  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_PRE     = 3'd1;
  localparam logic [2:0] OFF_COUNT   = 3'd2;
  localparam logic [2:0] OFF_COMPARE = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;

  logic             ctrl_en;
  logic             ctrl_auto;
  logic             ctrl_irq_en;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [15:0]      count;
  logic [15:0]      compare;
  logic             st_match;
  logic             st_wrap;

  logic       win_hit;
  logic       wr;
  logic [2:0] off;
  logic       wr_ctrl;
  logic       wr_pre;
  logic       wr_count;
  logic       wr_compare;
  logic       wr_status;
  logic       pre_done;
  logic       tick;
  logic       eval;
  logic       cnt_eq_cmp;
  logic       ev_match;
  logic       ev_wrap;

  assign win_hit    = (mem_addr[8:3] == BASE_ADDR[8:3]);
  assign off        = mem_addr[2:0];
  assign wr         = win_hit && (mem_cmd == MWRITE);
  assign wr_ctrl    = wr && (off == OFF_CTRL);
  assign wr_pre     = wr && (off == OFF_PRE);
  assign wr_count   = wr && (off == OFF_COUNT);
  assign wr_compare = wr && (off == OFF_COMPARE);
  assign wr_status  = wr && (off == OFF_STATUS);

  // A PRESCALE write restarts the divider, so it also suppresses that cycle's tick.
  assign pre_done   = (pre_cnt == prescale);
  assign tick       = ctrl_en && pre_done && !wr_pre;

  // A CPU write to COUNT overrides the whole tick evaluation, flags included.
  assign eval       = tick && !wr_count;
  assign cnt_eq_cmp = (count == compare);
  assign ev_match   = eval && cnt_eq_cmp;
  assign ev_wrap    = eval && !cnt_eq_cmp && (count == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      prescale    <= '0;
      pre_cnt     <= '0;
      count       <= 16'h0000;
      compare     <= 16'hFFFF;
      st_match    <= 1'b0;
      st_wrap     <= 1'b0;
    end else begin
      if (wr_pre) begin
        prescale <= write_data[PRE_W-1:0];
        pre_cnt  <= '0;
      end else if (ctrl_en) begin
        pre_cnt <= pre_done ? '0 : pre_cnt + PRE_W'(1);
      end

      if (wr_ctrl) begin
        ctrl_en     <= write_data[0];
        ctrl_auto   <= write_data[1];
        ctrl_irq_en <= write_data[2];
      end else if (ev_match && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end

      if (wr_count) begin
        count <= write_data;
      end else if (ev_match) begin
        if (ctrl_auto) count <= 16'h0000;
      end else if (eval) begin
        count <= count + 16'd1;
      end

      if (wr_compare) compare <= write_data;

      // Hardware set beats write-1-to-clear in the same cycle.
      st_match <= ev_match | (st_match & ~(wr_status & write_data[0]));
      st_wrap  <= ev_wrap  | (st_wrap  & ~(wr_status & write_data[1]));
    end
  end

  assign read_hit = win_hit && (mem_cmd == MREAD);
  assign irq      = ctrl_irq_en & st_match;

  always_comb begin
    read_data = 16'h0000;
    if (read_hit) begin
      case (off)
        OFF_CTRL:    read_data[2:0] = {ctrl_irq_en, ctrl_auto, ctrl_en};
        OFF_PRE:     read_data[PRE_W-1:0] = prescale;
        OFF_COUNT:   read_data = count;
        OFF_COMPARE: read_data = compare;
        OFF_STATUS:  read_data[1:0] = {st_wrap, st_match};
        default:     read_data = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed table-driven bench for mmio_timer
module tb_mmio_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_hit;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [8:0] A_CTRL = 9'h180;
  localparam logic [8:0] A_PRE  = 9'h181;
  localparam logic [8:0] A_CNT  = 9'h182;
  localparam logic [8:0] A_CMP  = 9'h183;
  localparam logic [8:0] A_STAT = 9'h184;

  mmio_timer #(.BASE_ADDR(9'h180), .PRE_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .read_hit   (read_hit),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
    logic        hit;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic bus_write(input logic [8:0] a, input logic [15:0] d);
    mem_cmd    = 2'b10;
    mem_addr   = a;
    write_data = d;
    @(negedge clk);
    mem_cmd    = 2'b00;
    write_data = 16'h0000;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [15:0] d, output logic h);
    mem_cmd  = 2'b01;
    mem_addr = a;
    #1;
    d = read_data;
    h = read_hit;
    mem_cmd = 2'b00;
  endtask

  task automatic rd_check(input string name, input logic [8:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic        h;
    bus_read(a, d, h);
    check(name, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_reset_table(input string tag);
    logic [15:0] d;
    logic        h;
    for (int i = 0; i < 10; i++) begin
      bus_read(tbl[i].addr, d, h);
      check($sformatf("%s data @%h", tag, tbl[i].addr), d, tbl[i].data);
      check($sformatf("%s hit @%h", tag, tbl[i].addr), {15'd0, h}, {15'd0, tbl[i].hit});
    end
    #1;
    check({tag, " irq"}, {15'd0, irq}, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{9'h180, 16'h0000, 1'b1};
    tbl[1] = '{9'h181, 16'h0000, 1'b1};
    tbl[2] = '{9'h182, 16'h0000, 1'b1};
    tbl[3] = '{9'h183, 16'hFFFF, 1'b1};
    tbl[4] = '{9'h184, 16'h0000, 1'b1};
    tbl[5] = '{9'h185, 16'h0000, 1'b1};
    tbl[6] = '{9'h186, 16'h0000, 1'b1};
    tbl[7] = '{9'h187, 16'h0000, 1'b1};
    tbl[8] = '{9'h140, 16'h0000, 1'b0};
    tbl[9] = '{9'h188, 16'h0000, 1'b0};

    reset      = 1'b0;
    mem_cmd    = 2'b00;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
    idle(2);
    reset = 1'b1;
    run_reset_table("reset");

    // Stray writes: neighbouring window and unused offsets.
    bus_write(9'h188, 16'hFFFF);
    bus_write(9'h18A, 16'h1234);
    bus_write(9'h185, 16'hFFFF);
    bus_write(9'h187, 16'hFFFF);
    run_reset_table("stray");

    // Prescale 3: one count per 4 cycles.
    bus_write(A_PRE, 16'h0003);
    bus_write(A_CMP, 16'hFFFF);
    bus_write(A_CTRL, 16'h0001);
    idle(3);
    rd_check("pre before first tick", A_CNT, 16'h0000);
    idle(1);
    rd_check("pre first tick", A_CNT, 16'h0001);
    idle(36);
    rd_check("pre 40 cycles", A_CNT, 16'h000A);
    rd_check("pre readback", A_PRE, 16'h0003);
    bus_write(A_CTRL, 16'h0000);
    idle(8);
    rd_check("pre hold", A_CNT, 16'h000A);

    // One-shot with irq.
    bus_write(A_PRE, 16'h0000);
    bus_write(A_CNT, 16'h0000);
    bus_write(A_CMP, 16'h0005);
    bus_write(A_CTRL, 16'h0005);
    idle(5);
    rd_check("os count 5", A_CNT, 16'h0005);
    rd_check("os no match yet", A_STAT, 16'h0000);
    idle(1);
    rd_check("os status", A_STAT, 16'h0001);
    rd_check("os ctrl", A_CTRL, 16'h0004);
    check("os irq", {15'd0, irq}, 16'h0001);
    idle(3);
    rd_check("os count holds", A_CNT, 16'h0005);
    bus_write(A_STAT, 16'h0001);
    #1;
    check("os irq cleared", {15'd0, irq}, 16'h0000);
    rd_check("os status cleared", A_STAT, 16'h0000);

    // Auto-reload.
    bus_write(A_CNT, 16'h0000);
    bus_write(A_CMP, 16'h0002);
    bus_write(A_PRE, 16'h0000);
    bus_write(A_CTRL, 16'h0003);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      rd_check($sformatf("ar count %0d", k), A_CNT, 16'((k + 1) % 3));
      rd_check($sformatf("ar status %0d", k), A_STAT, (k >= 2) ? 16'h0001 : 16'h0000);
    end
    rd_check("ar ctrl", A_CTRL, 16'h0003);
    bus_write(A_CTRL, 16'h0000);

    // Wrap.
    bus_write(A_STAT, 16'h0003);
    bus_write(A_CNT, 16'hFFFE);
    bus_write(A_CMP, 16'h0010);
    bus_write(A_CTRL, 16'h0001);
    idle(1);
    rd_check("wrap ffff", A_CNT, 16'hFFFF);
    rd_check("wrap status pre", A_STAT, 16'h0000);
    idle(1);
    rd_check("wrap zero", A_CNT, 16'h0000);
    rd_check("wrap status", A_STAT, 16'h0002);
    bus_write(A_CTRL, 16'h0000);

    // Match takes priority over wrap at FFFF.
    bus_write(A_STAT, 16'h0003);
    bus_write(A_CNT, 16'hFFFE);
    bus_write(A_CMP, 16'hFFFF);
    bus_write(A_CTRL, 16'h0001);
    idle(2);
    rd_check("mvw status", A_STAT, 16'h0001);
    rd_check("mvw count", A_CNT, 16'hFFFF);
    rd_check("mvw ctrl", A_CTRL, 16'h0000);

    // COUNT write during a matching tick discards the match.
    bus_write(A_STAT, 16'h0003);
    bus_write(A_CNT, 16'h0004);
    bus_write(A_CMP, 16'h0005);
    bus_write(A_CTRL, 16'h0001);
    idle(1);
    bus_write(A_CNT, 16'h1234);
    rd_check("col cnt value", A_CNT, 16'h1234);
    rd_check("col cnt status", A_STAT, 16'h0000);
    rd_check("col cnt ctrl", A_CTRL, 16'h0001);
    idle(1);
    rd_check("col cnt next", A_CNT, 16'h1235);
    bus_write(A_CTRL, 16'h0000);

    // W1C in the cycle MATCH sets.
    bus_write(A_STAT, 16'h0003);
    bus_write(A_CNT, 16'h0004);
    bus_write(A_CTRL, 16'h0001);
    idle(1);
    bus_write(A_STAT, 16'h0001);
    rd_check("col w1c status", A_STAT, 16'h0001);
    rd_check("col w1c ctrl", A_CTRL, 16'h0000);

    // CTRL write beats one-shot EN clear.
    bus_write(A_STAT, 16'h0003);
    bus_write(A_CNT, 16'h0004);
    bus_write(A_CTRL, 16'h0001);
    idle(1);
    bus_write(A_CTRL, 16'h0005);
    rd_check("col ctrl ctrl", A_CTRL, 16'h0005);
    rd_check("col ctrl status", A_STAT, 16'h0001);
    rd_check("col ctrl count", A_CNT, 16'h0005);
    bus_write(A_CTRL, 16'h0000);

    // Reset mid-count with a concurrent write.
    bus_write(A_STAT, 16'h0003);
    bus_write(A_CNT, 16'h0000);
    bus_write(A_CMP, 16'h0003);
    bus_write(A_PRE, 16'h0000);
    bus_write(A_CTRL, 16'h0007);
    idle(5);
    #1;
    check("mid irq before reset", {15'd0, irq}, 16'h0001);
    reset      = 1'b0;
    mem_cmd    = 2'b10;
    mem_addr   = A_CNT;
    write_data = 16'h0055;
    @(negedge clk);
    reset   = 1'b1;
    mem_cmd = 2'b00;
    run_reset_table("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/counter peripheral on the CPU memory bus, in the I/O half of the address space (mem_addr[8]=1), alongside the LED and switch ports.
- Consumes the CPU's mem_cmd, mem_addr and write_data.
- Produces read_data plus a read_hit qualifier; the top-level read mux selects this block's data when read_hit=1.
- Provides a prescaled up-counter with compare match, one-shot or auto-reload mode, sticky status flags and an irq level output.

Parameters:
- BASE_ADDR, 9'h180, base of the 8-word register window; low 3 bits must be 0.
- PRE_W, 16, width of the prescale divisor register and prescale counter.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets all state).
- mem_cmd  input  2  bus command: 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE.
- mem_addr  input  9  bus address.
- write_data  input  16  bus write data.
- read_data  output  16  register read data; 16'h0000 when read_hit=0.
- read_hit  output  1  1 when mem_cmd==MREAD and mem_addr[8:3]==BASE_ADDR[8:3].
- irq  output  1  equals CTRL.IRQ_EN & STATUS.MATCH.

Behaviour:
- Window hit: mem_addr[8:3]==BASE_ADDR[8:3]. Register offset is mem_addr[2:0].
- Writes take effect at the rising clk edge only when mem_cmd==MWRITE and the window hits. MREAD and MNONE never change state.
- Register map:
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; bits 15:3 read 0, writes to them ignored.
  - 1 PRESCALE: the counter ticks once every PRESCALE+1 clk cycles. Upper bits read 0 if PRE_W<16.
  - 2 COUNT: 16-bit current count, read/write.
  - 3 COMPARE: 16-bit match value.
  - 4 STATUS: bit0 MATCH, bit1 WRAP; both sticky, write-1-to-clear; other bits read 0.
  - 5-7: read 16'h0000; writes ignored.
- Reads are combinational, side-effect free and zero-latency (same cycle as mem_cmd/mem_addr), matching the RAM read path.
- Reset values: CTRL 0, PRESCALE 0, COUNT 0, COMPARE 16'hFFFF, STATUS 0, internal prescale counter pre_cnt 0. Consequently irq=0 and read_data=0.
- Prescaler:
  - While EN=1, pre_cnt increments each cycle.
  - When pre_cnt==PRESCALE, pre_cnt<=0 and an internal tick is asserted for that cycle.
  - While EN=0, pre_cnt and COUNT hold their values.
- Tick action, evaluated on the pre-update COUNT:
  - COUNT==COMPARE: MATCH<=1. If AUTO_RELOAD=1, COUNT<=0 and EN stays 1. If AUTO_RELOAD=0 (one-shot), EN<=0 and COUNT holds at COMPARE.
  - Else if COUNT==16'hFFFF: COUNT<=0 and WRAP<=1.
  - Else: COUNT<=COUNT+1.
- Match is checked before wrap: with COMPARE=16'hFFFF, reaching FFFF sets MATCH, not WRAP.
- Simultaneous events:
  - CPU write to COUNT in a tick cycle: the written value wins; the match/wrap evaluation of that tick is discarded.
  - CPU write to CTRL in a cycle where one-shot clears EN: the CPU write wins.
  - Write-1-to-clear of a flag in the same cycle hardware sets it: the flag ends up set.
  - Write to PRESCALE: also clears pre_cnt to 0 that cycle, and no tick occurs that cycle.
  - Write to CTRL setting EN 0->1: pre_cnt restarts from its held value. It is not cleared.
- reset==0 mid-count: all state returns to reset values at that edge, whatever the bus activity.
- irq is a level output and stays high until MATCH is cleared or IRQ_EN is cleared.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read offsets 0-4 -> 0000,0000,0000,FFFF,0000; irq=0. Read 9'h140 -> read_hit=0, read_data=0000.
- Prescale count: PRESCALE=3, COMPARE=FFFF, CTRL=1 -> COUNT advances by 1 every 4 cycles; after 40 cycles COUNT=10. Write CTRL=0 -> COUNT holds.
- One-shot with irq: PRESCALE=0, COUNT=0, COMPARE=5, CTRL=5 (EN|IRQ_EN) -> after 6 ticks STATUS=0001, irq=1, CTRL reads 0004, COUNT stays 5. Write STATUS=1 -> irq=0 the next cycle.
- Auto-reload: COMPARE=2, CTRL=3, PRESCALE=0 -> COUNT sequence 0,1,2,0,1,2,...; MATCH set after the first match.
- Wrap: COUNT=FFFE, COMPARE=0010, CTRL=1, PRESCALE=0 -> COUNT goes FFFF, then 0000 with STATUS=0002.
- Collisions:
  - Write COUNT=1234 in a tick cycle -> COUNT=1234 next cycle.
  - Write STATUS=1 in the cycle MATCH is set -> MATCH remains 1.
  - MWRITE to 9'h188 -> no register changes.
